// File: rtl/axi4lite_cmd_sequencer_pkg.sv
// Shared types for the AXI4-Lite command sequencer: bus widths, FSM states and
// the queued command record.
package axi4lite_cmd_sequencer_pkg;

   localparam int unsigned ADDRWIDTH = 32;
   localparam int unsigned DATAWIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } seq_state_t;

   typedef struct packed {
      logic                 write;
      logic [ADDRWIDTH-1:0] addr;
      logic [DATAWIDTH-1:0] data;
   } seq_cmd_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == '1) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/axi4lite_cmd_sequencer_if.sv
// Command-side and DUV-side signals of the sequencer. Statistics counters are
// present only when AXI4LITE_SEQ_STATS_EN is defined.
interface axi4lite_cmd_sequencer_if
   import axi4lite_cmd_sequencer_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
);
   localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 cmd_write;
   logic [ADDRWIDTH-1:0] cmd_addr;
   logic [DATAWIDTH-1:0] cmd_data;
   logic                 txn_done;
   logic                 rd_en;
   logic                 wr_en;
   logic [ADDRWIDTH-1:0] Read_Address;
   logic [ADDRWIDTH-1:0] Write_Address;
   logic [DATAWIDTH-1:0] Write_Data;
   logic                 busy;
   logic                 timeout_err;
   logic [CNTW-1:0]      fifo_count;
`ifdef AXI4LITE_SEQ_STATS_EN
   logic [15:0]          wr_issued;
   logic [15:0]          rd_issued;
   logic [15:0]          timeouts;
`endif

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_data, txn_done,
      output cmd_ready, rd_en, wr_en, Read_Address, Write_Address, Write_Data,
             busy, timeout_err, fifo_count
`ifdef AXI4LITE_SEQ_STATS_EN
      , output wr_issued, rd_issued, timeouts
`endif
   );

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_data, txn_done,
      input  cmd_ready, rd_en, wr_en, Read_Address, Write_Address, Write_Data,
             busy, timeout_err, fifo_count
`ifdef AXI4LITE_SEQ_STATS_EN
      , input wr_issued, rd_issued, timeouts
`endif
   );

endinterface

// File: rtl/axi4lite_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap modulo DEPTH, count is one bit wider
// so full and empty stay distinguishable.
module axi4lite_cmd_fifo
   import axi4lite_cmd_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  seq_cmd_t                 data_i,
   input  logic                     pop_i,
   output seq_cmd_t                 data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   seq_cmd_t        mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q, count_d;
   logic            do_push, do_pop;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/axi4lite_cmd_sequencer.sv
// Issues queued AXI4-Lite commands one at a time as single-cycle strobes and
// waits for txn_done or a timeout. Optional counters: AXI4LITE_SEQ_STATS_EN.
module axi4lite_cmd_sequencer
   import axi4lite_cmd_sequencer_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   axi4lite_cmd_sequencer_if.slave  bus
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   seq_state_t           state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic                 wr_en_q, wr_en_d;
   logic                 rd_en_q, rd_en_d;
   logic [ADDRWIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [ADDRWIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATAWIDTH-1:0] wr_data_q, wr_data_d;

   logic                 push, pop, full, empty, timeout_hit;
   seq_cmd_t             push_cmd, head;
   logic [CW-1:0]        count;

   assign push     = bus.cmd_valid && !full;
   assign push_cmd = '{write: bus.cmd_write, addr: bus.cmd_addr, data: bus.cmd_data};

   axi4lite_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .data_i  (push_cmd),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   // Strobe and address registers are loaded on the IDLE->ISSUE edge so they
   // become visible during ISSUE, while the entry itself is popped in ISSUE.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      wr_en_d     = 1'b0;
      rd_en_d     = 1'b0;
      rd_addr_d   = rd_addr_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      pop         = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               state_d = ISSUE;
               wr_en_d = head.write;
               rd_en_d = !head.write;
               if (head.write) begin
                  wr_addr_d = head.addr;
                  wr_data_d = head.data;
               end else begin
                  rd_addr_d = head.addr;
               end
            end
         end
         ISSUE: begin
            pop     = 1'b1;
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.txn_done) begin
               state_d = IDLE;
               timer_d = '0;
            end else if (timer_q == TLAST) begin
               timeout_hit = 1'b1;
               state_d     = IDLE;
               timer_d     = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign bus.cmd_ready     = !full;
   assign bus.wr_en         = wr_en_q;
   assign bus.rd_en         = rd_en_q;
   assign bus.Read_Address  = rd_addr_q;
   assign bus.Write_Address = wr_addr_q;
   assign bus.Write_Data    = wr_data_q;
   assign bus.busy          = (state_q != IDLE) || !empty;
   assign bus.timeout_err   = timeout_hit;
   assign bus.fifo_count    = count;

`ifdef AXI4LITE_SEQ_STATS_EN
   logic [15:0] wr_cnt_q, rd_cnt_q, to_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         to_cnt_q <= '0;
      end else begin
         if (wr_en_q)     wr_cnt_q <= sat_inc16(wr_cnt_q);
         if (rd_en_q)     rd_cnt_q <= sat_inc16(rd_cnt_q);
         if (timeout_hit) to_cnt_q <= sat_inc16(to_cnt_q);
      end
   end

   assign bus.wr_issued = wr_cnt_q;
   assign bus.rd_issued = rd_cnt_q;
   assign bus.timeouts  = to_cnt_q;
`endif

endmodule

// File: tb/tb_axi4lite_cmd_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a transaction/timing-level reference model.
module tb_axi4lite_cmd_sequencer;

   localparam int unsigned DEPTH = 4;
   localparam int          TMO   = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi4lite_cmd_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();

   axi4lite_cmd_sequencer #(
      .FIFO_DEPTH (DEPTH),
      .TIMEOUT    (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit          w;
      logic [31:0] a;
      logic [31:0] d;
   } mcmd_t;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   // Reference model: queued commands, in-flight transaction and its strobe cycle
   mcmd_t       fq[$];
   bit          m_act, m_sched, m_acc;
   int          m_s, cyc;
   logic [31:0] m_ra, m_wa, m_wd;
   int          n_wr, n_rd, n_to;
   int          done_lat;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      fq.delete();
      m_act = 0; m_sched = 0; m_acc = 0; m_s = 0;
      m_ra = '0; m_wa = '0; m_wd = '0;
      n_wr = 0; n_rd = 0; n_to = 0;
   endtask

   task automatic step(input bit v, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit dn_extra);
      bit    dn, exp_wr, exp_rd, exp_to, fin, strobe;
      mcmd_t c;
      @(negedge clk);
      dn = dn_extra || (m_act && done_lat > 0 && (cyc - m_s) == done_lat);
      bus.cmd_valid = v;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_data  = d;
      bus.txn_done  = dn;
      #1;
`ifdef AXI4LITE_SEQ_STATS_EN
      check("wr_issued", bus.wr_issued, n_wr);
      check("rd_issued", bus.rd_issued, n_rd);
      check("timeouts",  bus.timeouts,  n_to);
`endif
      exp_wr = 0; exp_rd = 0; exp_to = 0; fin = 0; strobe = 0;
      if (m_sched) begin
         strobe = 1; m_sched = 0; m_act = 1; m_s = cyc; c = fq[0];
         if (c.w) begin exp_wr = 1; m_wa = c.a; m_wd = c.d; n_wr++; end
         else     begin exp_rd = 1; m_ra = c.a; n_rd++; end
      end else if (m_act) begin
         if (dn) fin = 1;
         else if ((cyc - m_s) == TMO) begin exp_to = 1; fin = 1; n_to++; end
      end
      check("wr_en",         bus.wr_en,         exp_wr);
      check("rd_en",         bus.rd_en,         exp_rd);
      check("timeout_err",   bus.timeout_err,   exp_to);
      check("Write_Address", bus.Write_Address, m_wa);
      check("Write_Data",    bus.Write_Data,    m_wd);
      check("Read_Address",  bus.Read_Address,  m_ra);
      check("busy",          bus.busy,          m_act || fq.size() != 0);
      check("cmd_ready",     bus.cmd_ready,     fq.size() < DEPTH);
      check("fifo_count",    bus.fifo_count,    fq.size());
      m_acc = v && (fq.size() < DEPTH);
      if (!m_act && fq.size() != 0) m_sched = 1;
      if (fin) m_act = 0;
      if (strobe) void'(fq.pop_front());
      if (m_acc) begin
         c.w = w; c.a = a; c.d = d;
         fq.push_back(c);
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0);
   endtask

   task automatic offer(input bit w, input logic [31:0] a, input logic [31:0] d);
      bit ok = 0;
      for (int k = 0; k < 64 && !ok; k++) begin
         step(1, w, a, d, 0);
         ok = m_acc;
      end
      if (!ok) check("offer_accept", 0, 1);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1;
      bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0;
      bus.cmd_data  = '0; bus.txn_done = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         check("rst_wr_en",   bus.wr_en,         0);
         check("rst_rd_en",   bus.rd_en,         0);
         check("rst_waddr",   bus.Write_Address, 0);
         check("rst_wdata",   bus.Write_Data,    0);
         check("rst_raddr",   bus.Read_Address,  0);
         check("rst_busy",    bus.busy,          0);
         check("rst_count",   bus.fifo_count,    0);
         check("rst_timeout", bus.timeout_err,   0);
      end
      rst = 0;
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0;
      bus.cmd_data  = '0; bus.txn_done  = 0;
      cyc = 0; done_lat = 0;
      model_reset();
      do_reset(2);

      // 1: single write, completion two cycles after the strobe
      done_lat = 2;
      offer(1, 32'h04, 32'hDEADBEEF);
      idle(8);

      // 2: read with no completion -> timeout
      done_lat = 0;
      offer(0, 32'h08, 32'h0);
      idle(TMO + 6);

      // 3: hold the sequencer in WAIT, then overfill the queue
      offer(0, 32'h10, 32'h0);
      idle(3);
      for (int i = 0; i < 5; i++) offer(1, 32'h100 + 32'(i * 4), 32'hA000 + 32'(i));
      done_lat = 2;
      idle(6 * TMO);

      // 4: completion on the last timer cycle beats the timeout
      done_lat = TMO;
      offer(1, 32'h20, 32'h1111);
      offer(0, 32'h24, 32'h0);
      idle(3 * TMO);

      // 5: reset while waiting with two queued commands
      done_lat = 0;
      offer(1, 32'h30, 32'h2222);
      idle(3);
      offer(0, 32'h34, 32'h0);
      offer(1, 32'h38, 32'h3333);
      idle(2);
      do_reset(1);
      idle(6);

      // 6: statistics scenario (3 writes, 2 reads, 1 timeout)
      done_lat = 2;
      offer(1, 32'h40, 32'h1);
      offer(1, 32'h44, 32'h2);
      offer(0, 32'h48, 32'h0);
      offer(0, 32'h4C, 32'h0);
      idle(20);
      done_lat = 0;
      offer(1, 32'h50, 32'h3);
      idle(TMO + 6);
`ifdef AXI4LITE_SEQ_STATS_EN
      check("stats_wr", bus.wr_issued, 3);
      check("stats_rd", bus.rd_issued, 2);
      check("stats_to", bus.timeouts,  1);
`endif

      // Random traffic with stray completions and occasional resets
      for (int blk = 0; blk < 30; blk++) begin
         done_lat = int'($urandom_range(0, TMO + 2));
         for (int i = 0; i < 50; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 $urandom(), $urandom(), $urandom_range(0, 11) == 0);
         if (blk % 8 == 7) do_reset(1);
      end
      idle(2 * TMO);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
